// File: rtl/l2_request_scheduler.sv
// L2 request scheduler: arbitrates L1 requests against bus snoops and
// sequences tag lookup, MESI write-back/fill traffic and the MESI/LRU update.
module l2_request_scheduler #(
    parameter int WAYS      = 8,
    parameter int ADDR_BITS = 32,
    parameter int SNOOP_MAX = 2,
    localparam int WAY_BITS = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 l1Valid,
    input  logic [7:0]           l1Cmd,
    input  logic [ADDR_BITS-1:0] l1Addr,
    output logic                 l1Ready,
    output logic                 l1Done,
    output logic                 l1Hit,
    input  logic                 snpValid,
    input  logic [7:0]           snpCmd,
    input  logic [ADDR_BITS-1:0] snpAddr,
    output logic                 snpReady,
    output logic                 snpDone,
    output logic [1:0]           snpResult,
    output logic                 lookupEn,
    output logic [ADDR_BITS-1:0] lookupAddr,
    input  logic                 tagHit,
    input  logic [WAY_BITS-1:0]  hitWay,
    input  logic [3:0]           hitMesi,
    input  logic [WAY_BITS-1:0]  victimWay,
    input  logic [3:0]           victimMesi,
    input  logic [ADDR_BITS-1:0] victimAddr,
    output logic                 writeEn,
    output logic [WAY_BITS-1:0]  writeWay,
    output logic [3:0]           writeMesi,
    output logic                 lruTouch,
    output logic                 busReq,
    output logic [7:0]           busOp,
    output logic [ADDR_BITS-1:0] busAddr,
    input  logic                 busDone,
    input  logic                 busShared,
    output logic                 cmdErr
);
    localparam logic [7:0] C_R = 8'd82;
    localparam logic [7:0] C_W = 8'd87;
    localparam logic [7:0] C_M = 8'd77;
    localparam logic [7:0] C_I = 8'd73;
    localparam logic [3:0] MESI_M = 4'b1000;
    localparam logic [3:0] MESI_E = 4'b0100;
    localparam logic [3:0] MESI_S = 4'b0010;
    localparam logic [3:0] MESI_I = 4'b0001;
    localparam int SW = $clog2(SNOOP_MAX + 2);
    localparam logic [SW-1:0] SMAX = SW'(SNOOP_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_RESOLVE, S_WRBACK, S_FILL, S_UPDATE, S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  snp_q, snp_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [ADDR_BITS-1:0]  vaddr_q, vaddr_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic [3:0]            mesi_q, mesi_d;
    logic                  hit_q, hit_d;
    logic                  wen_q, wen_d;
    logic                  lru_q, lru_d;
    logic [1:0]            res_q, res_d;

    logic snp_win, l1_legal, snp_legal, valid_hit;

    assign snp_win   = snpValid && (!l1Valid || streak_q < SMAX);
    assign l1_legal  = (l1Cmd == C_R) || (l1Cmd == C_W) || (l1Cmd == C_I);
    assign snp_legal = (snpCmd == C_R) || (snpCmd == C_M) || (snpCmd == C_I);
    // a tag match on an Invalid line counts as a miss
    assign valid_hit = tagHit && (hitMesi != MESI_I) && (hitMesi != 4'b0000);
    assign lookupAddr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            streak_q <= '0;
            snp_q    <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            vaddr_q  <= '0;
            way_q    <= '0;
            mesi_q   <= '0;
            hit_q    <= 1'b0;
            wen_q    <= 1'b0;
            lru_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            snp_q    <= snp_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            vaddr_q  <= vaddr_d;
            way_q    <= way_d;
            mesi_q   <= mesi_d;
            hit_q    <= hit_d;
            wen_q    <= wen_d;
            lru_q    <= lru_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        snp_d    = snp_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        vaddr_d  = vaddr_q;
        way_d    = way_q;
        mesi_d   = mesi_q;
        hit_d    = hit_q;
        wen_d    = wen_q;
        lru_d    = lru_q;
        res_d    = res_q;
        l1Ready   = 1'b0;
        l1Done    = 1'b0;
        l1Hit     = 1'b0;
        snpReady  = 1'b0;
        snpDone   = 1'b0;
        snpResult = 2'b00;
        lookupEn  = 1'b0;
        writeEn   = 1'b0;
        writeWay  = '0;
        writeMesi = 4'b0000;
        lruTouch  = 1'b0;
        busReq    = 1'b0;
        busOp     = 8'h00;
        busAddr   = '0;
        cmdErr    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // no accept pulse while reset is held
                if (rst_n && snp_win) begin
                    snpReady = 1'b1;
                    snp_d    = 1'b1;
                    cmd_d    = snpCmd;
                    addr_d   = snpAddr;
                    if (l1Valid) streak_d = streak_q + 1'b1;
                    state_d  = snp_legal ? S_LOOKUP : S_ERR;
                end else if (rst_n && l1Valid) begin
                    l1Ready  = 1'b1;
                    snp_d    = 1'b0;
                    cmd_d    = l1Cmd;
                    addr_d   = l1Addr;
                    streak_d = '0;
                    state_d  = l1_legal ? S_LOOKUP : S_ERR;
                end
            end
            S_LOOKUP: begin
                lookupEn = 1'b1;
                state_d  = S_RESOLVE;
            end
            S_RESOLVE: begin
                hit_d   = valid_hit;
                wen_d   = 1'b0;
                lru_d   = 1'b0;
                res_d   = 2'b00;
                way_d   = hitWay;
                vaddr_d = addr_q;
                mesi_d  = MESI_I;
                state_d = S_UPDATE;
                if (snp_q) begin
                    if (valid_hit) begin
                        wen_d  = 1'b1;
                        res_d  = (hitMesi == MESI_M) ? 2'b10 : 2'b01;
                        mesi_d = (cmd_q == C_R) ? MESI_S : MESI_I;
                        if (hitMesi == MESI_M) state_d = S_WRBACK;
                    end
                end else if (valid_hit) begin
                    if (cmd_q == C_R) begin
                        lru_d = 1'b1;
                    end else if (cmd_q == C_W) begin
                        wen_d  = 1'b1;
                        lru_d  = 1'b1;
                        mesi_d = MESI_M;
                        // shared copy needs ownership (RFO) before the write
                        if (hitMesi == MESI_S) state_d = S_FILL;
                    end else begin
                        wen_d = 1'b1;
                    end
                end else if (cmd_q != C_I) begin
                    wen_d   = 1'b1;
                    lru_d   = 1'b1;
                    way_d   = victimWay;
                    vaddr_d = victimAddr;
                    mesi_d  = (cmd_q == C_W) ? MESI_M : MESI_E;
                    state_d = (victimMesi == MESI_M) ? S_WRBACK : S_FILL;
                end
            end
            S_WRBACK: begin
                busReq  = 1'b1;
                busOp   = C_W;
                busAddr = vaddr_q;
                if (busDone) state_d = snp_q ? S_UPDATE : S_FILL;
            end
            S_FILL: begin
                busReq  = 1'b1;
                busOp   = (cmd_q == C_R) ? C_R : C_M;
                busAddr = addr_q;
                if (busDone) begin
                    if (cmd_q == C_R && busShared) mesi_d = MESI_S;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                l1Done    = !snp_q;
                l1Hit     = !snp_q && hit_q;
                snpDone   = snp_q;
                snpResult = snp_q ? res_q : 2'b00;
                writeEn   = wen_q;
                writeWay  = (wen_q || lru_q) ? way_q : '0;
                writeMesi = wen_q ? mesi_q : 4'b0000;
                lruTouch  = lru_q;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                cmdErr  = 1'b1;
                l1Done  = !snp_q;
                snpDone = snp_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
